stream_fifo: RTL
================

// Module: stream_fifo
// PURPOSE
//  Parametrised valid/ready FIFO with arbitrary width and depth (depth need not be a power of 2).
//  Replaces fixed 16-bit, power-of-2, DEPTH-1-usable buffering between stdio producers/consumers.
//  Adds an occupancy count, almost-full/almost-empty flags and a synchronous flush.
//  Sits between front-panel/stdio sources, the TOY core and output sinks.
// PARAMETERS
//  WIDTH     16  data word width in bits (>=1)
//  DEPTH     4   number of storage entries, all usable (>=1, any integer)
//  AF_LEVEL  DEPTH-1  almost_full_o asserts when count >= AF_LEVEL
//  AE_LEVEL  1   almost_empty_o asserts when count <= AE_LEVEL
//  CW        $clog2(DEPTH+1)  derived; width of count_o, not overridden
// PORTS
//  clk_i           in   1      clock, rising edge
//  rst_ni          in   1      reset, asynchronous, active-low
//  flush_i         in   1      synchronous clear of all contents
//  in_val_i        in   1      producer word valid
//  in_rdy_o        out  1      FIFO can accept a word
//  in_data_i       in   WIDTH  producer data
//  out_val_o       out  1      FIFO holds a word for the consumer
//  out_rdy_i       in   1      consumer accepts word
//  out_data_o      out  WIDTH  head-of-queue data
//  count_o         out  CW     current occupancy, 0..DEPTH
//  almost_full_o   out  1      count_o >= AF_LEVEL
//  almost_empty_o  out  1      count_o <= AE_LEVEL
// BEHAVIOUR
//  - Reset (rst_ni=0, async): wptr=rptr=0, count=0; in_rdy_o=1, out_val_o=0, count_o=0,
//    almost_empty_o=1, almost_full_o=(AF_LEVEL==0). out_data_o is don't-care while out_val_o=0.
//    Storage array is not reset. Reset mid-transfer drops all contents; no partial word survives.
//  - push = in_val_i & in_rdy_o; pop = out_val_o & out_rdy_i. Transfers occur on rising edge.
//  - in_rdy_o = (count != DEPTH) & ~flush_i. out_val_o = (count != 0) & ~flush_i.
//    Neither ready nor valid depends combinationally on the opposite side's handshake.
//  - Pointers run 0..DEPTH-1 and wrap explicitly (DEPTH-1 -> 0), not by modulo on bit width.
//  - count_next = count + push - pop; push & pop in the same cycle leaves count unchanged.
//  - Full (count==DEPTH): in_rdy_o=0, so no push occurs even if a pop happens that cycle.
//    The freed slot is offered on the next cycle.
//  - Empty (count==0): out_val_o=0; a pushed word appears on out_data_o one cycle later.
//  - out_data_o = mem[rptr], driven combinationally from storage. Head stays stable while
//    out_val_o=1 & out_rdy_i=0.
//  - flush_i=1: no push or pop that cycle; on the next edge wptr=rptr=count=0.
//    flush_i takes priority over in_val_i/out_rdy_i.
//  - Overflow and underflow are impossible by construction. Sim assertion: count_o <= DEPTH.
//  - Flags are combinational from count. Elaboration error if AE_LEVEL > DEPTH or AF_LEVEL > DEPTH.
// CONFIGURATION
//  STREAM_FIFO_BYPASS_EN defined:
//    - When count==0, in_val_i=1 and flush_i=0: out_val_o=1 and out_data_o=in_data_i,
//      combinationally.
//    - If out_rdy_i=1 as well, the word passes straight through. It is not written, and
//      pointers and count are unchanged. Zero-cycle latency.
//    - If out_rdy_i=0, the word is written normally.
//  STREAM_FIFO_BYPASS_EN undefined:
//    - Minimum latency is 1 cycle. No combinational in->out path.
// TESTING
//  1. Reset with DEPTH=3: push A,B,C back-to-back, out_rdy_i=0 -> in_rdy_o=0 after 3rd push,
//     count_o=3, almost_full_o=1. Then pop 3 -> data A,B,C in order, count_o=0, out_val_o=0.
//  2. DEPTH=3 wrap: push/pop 10 words 0x0001..0x000A with random stalls -> order preserved,
//     pointers wrap 2->0, count_o never exceeds 3.
//  3. Full with simultaneous pop, DEPTH=2, count=2, in_val_i=1, out_rdy_i=1 -> pop only,
//     count_o=1. Push accepted on the next cycle.
//  4. Steady stream, count=1, push & pop every cycle for 8 cycles -> count_o stays 1,
//     throughput 1 word/cycle.
//  5. flush_i with count=2 and in_val_i=1 -> no push that cycle. Next cycle count_o=0,
//     out_val_o=0, almost_empty_o=1.
//  6. Async reset asserted mid-stream (count=2) -> outputs reach reset values immediately.
//     With STREAM_FIFO_BYPASS_EN: empty, in_val_i=1, out_rdy_i=1, data 0xBEEF -> out_data_o=0xBEEF
//     the same cycle, count_o stays 0.

Source files
------------

// File: rtl/stream_fifo.sv
// Valid/ready FIFO of any width and depth with occupancy count, level flags and flush.
// Optional zero-latency pass-through when empty: define STREAM_FIFO_BYPASS_EN.
module stream_fifo #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_val_i,
    output logic             in_rdy_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_val_o,
    input  logic             out_rdy_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [CW-1:0]    count_o,
    output logic             almost_full_o,
    output logic             almost_empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

    if (WIDTH < 1) begin : g_bad_width
        $error("stream_fifo: WIDTH must be >= 1");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("stream_fifo: DEPTH must be >= 1");
    end
    if (AE_LEVEL > DEPTH || AE_LEVEL < 0) begin : g_bad_ae
        $error("stream_fifo: AE_LEVEL out of range");
    end
    if (AF_LEVEL > DEPTH || AF_LEVEL < 0) begin : g_bad_af
        $error("stream_fifo: AF_LEVEL out of range");
    end

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;

    logic empty;
    logic full;
    logic push;
    logic pop;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    assign in_rdy_o = ~full & ~flush_i;

`ifdef STREAM_FIFO_BYPASS_EN
    logic pass;

    // An empty FIFO presents the incoming word directly; if it is taken at
    // once, storage is never touched.
    assign out_val_o  = (~empty | in_val_i) & ~flush_i;
    assign out_data_o = empty ? in_data_i : mem[rptr];
    assign pass       = empty & in_val_i & out_rdy_i & ~flush_i;
    assign push       = in_val_i & in_rdy_o & ~pass;
    assign pop        = out_val_o & out_rdy_i & ~empty;
`else
    assign out_val_o  = ~empty & ~flush_i;
    assign out_data_o = mem[rptr];
    assign push       = in_val_i & in_rdy_o;
    assign pop        = out_val_o & out_rdy_i;
`endif

    assign count_o        = count;
    assign almost_full_o  = (count >= AF_C);
    assign almost_empty_o = (count <= AE_C);

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr] <= in_data_i;
        end
    end

    // Pointers wrap at DEPTH-1 so non-power-of-2 depths use every slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= (wptr == LAST) ? '0 : wptr + PW'(1);
            end
            if (pop) begin
                rptr <= (rptr == LAST) ? '0 : rptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (count <= DEPTH_C)
            else $error("stream_fifo: occupancy above DEPTH");
        end
    end
`endif

endmodule
